// File: rtl/rv_ctrl_fsm.sv
// rv_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC control sequencer for the
// addi/bne datapath. Fetches over a req/ack handshake, decodes into
// registered datapath controls, and updates PC from the datapath EQ flag.
module rv_ctrl_fsm #(
    parameter int unsigned        A_WIDTH  = 32,
    parameter int unsigned        D_WIDTH  = 32,
    parameter int unsigned        R_WIDTH  = 5,
    parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [D_WIDTH-1:0] imem_data,
    input  logic               EQ,
    output logic               ALUsrc,
    output logic               ALUctrl,
    output logic [D_WIDTH-1:0] ImmOp,
    output logic               WE3,
    output logic [R_WIDTH-1:0] AD1,
    output logic [R_WIDTH-1:0] AD2,
    output logic [R_WIDTH-1:0] AD3,
    output logic [A_WIDTH-1:0] pc,
    output logic               illegal,
    output logic [31:0]        retired
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC} state_e;
    typedef enum logic [1:0] {OP_ILL, OP_ADDI, OP_BNE} op_e;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [D_WIDTH-1:0] instr_q, instr_d;
    logic [A_WIDTH-1:0] pc_q, pc_d;
    logic               req_q, req_d;
    logic               alusrc_q, alusrc_d;
    logic               aluctrl_q, aluctrl_d;
    logic [D_WIDTH-1:0] imm_q, imm_d;
    logic               we3_q, we3_d;
    logic [R_WIDTH-1:0] ad1_q, ad1_d;
    logic [R_WIDTH-1:0] ad2_q, ad2_d;
    logic [R_WIDTH-1:0] ad3_q, ad3_d;
    logic               illegal_q, illegal_d;
    logic [31:0]        retired_q, retired_d;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [D_WIDTH-1:0] imm_i;
    logic [D_WIDTH-1:0] imm_b;
    logic [A_WIDTH-1:0] pc_seq;
    logic [A_WIDTH-1:0] pc_br;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign imm_i  = {{(D_WIDTH-12){instr_q[31]}}, instr_q[31:20]};
    assign imm_b  = {{(D_WIDTH-13){instr_q[31]}}, instr_q[31], instr_q[7],
                     instr_q[30:25], instr_q[11:8], 1'b0};
    assign pc_seq = pc_q + A_WIDTH'(3'd4);
    assign pc_br  = pc_q + A_WIDTH'($signed(imm_q));

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= OP_ILL;
            instr_q   <= '0;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            alusrc_q  <= 1'b0;
            aluctrl_q <= 1'b0;
            imm_q     <= '0;
            we3_q     <= 1'b0;
            ad1_q     <= '0;
            ad2_q     <= '0;
            ad3_q     <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            alusrc_q  <= alusrc_d;
            aluctrl_q <= aluctrl_d;
            imm_q     <= imm_d;
            we3_q     <= we3_d;
            ad1_q     <= ad1_d;
            ad2_q     <= ad2_d;
            ad3_q     <= ad3_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one state
    // ahead so they are valid during the state they belong to
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        req_d     = req_q;
        alusrc_d  = alusrc_q;
        aluctrl_d = aluctrl_q;
        imm_d     = imm_q;
        we3_d     = 1'b0;
        ad1_d     = ad1_q;
        ad2_d     = ad2_q;
        ad3_d     = ad3_q;
        illegal_d = illegal_q;
        retired_d = retired_q;

        unique case (state_q)
            S_FETCH: begin
                req_d = 1'b1;
                if (req_q && imem_ack) begin
                    instr_d = imem_data;
                    req_d   = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ad1_d = R_WIDTH'(instr_q[19:15]);
                ad2_d = R_WIDTH'(instr_q[24:20]);
                ad3_d = R_WIDTH'(instr_q[11:7]);
                if (opcode == OPC_OPIMM && funct3 == F3_ADDI) begin
                    op_d      = OP_ADDI;
                    imm_d     = imm_i;
                    alusrc_d  = 1'b1;
                    aluctrl_d = 1'b0;
                    we3_d     = 1'b1;
                end else if (opcode == OPC_BRANCH && funct3 == F3_BNE) begin
                    op_d      = OP_BNE;
                    imm_d     = imm_b;
                    alusrc_d  = 1'b0;
                    aluctrl_d = 1'b1;
                end else begin
                    op_d      = OP_ILL;
                    imm_d     = '0;
                    alusrc_d  = 1'b0;
                    aluctrl_d = 1'b0;
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                retired_d = retired_q + 32'd1;
                // Raise req on the way back so FETCH starts requesting at once
                req_d     = 1'b1;
                state_d   = S_FETCH;
                case (op_q)
                    OP_ADDI: pc_d = pc_seq;
                    OP_BNE:  pc_d = EQ ? pc_seq : pc_br;
                    default: begin
                        pc_d      = pc_seq;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ALUsrc    = alusrc_q;
    assign ALUctrl   = aluctrl_q;
    assign ImmOp     = imm_q;
    assign WE3       = we3_q;
    assign AD1       = ad1_q;
    assign AD2       = ad2_q;
    assign AD3       = ad3_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Scoreboard bench for rv_ctrl_fsm: the stimulus process pushes the expected
// retirement record of each instruction, a monitor pops it on every retire.
module tb_rv_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        EQ;
    logic        ALUsrc;
    logic        ALUctrl;
    logic [31:0] ImmOp;
    logic        WE3;
    logic [4:0]  AD1, AD2, AD3;
    logic [31:0] pc;
    logic        illegal;
    logic [31:0] retired;

    rv_ctrl_fsm #(
        .A_WIDTH (32),
        .D_WIDTH (32),
        .R_WIDTH (5),
        .RESET_PC(32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .imem_req (imem_req),
        .imem_addr(imem_addr),
        .imem_ack (imem_ack),
        .imem_data(imem_data),
        .EQ       (EQ),
        .ALUsrc   (ALUsrc),
        .ALUctrl  (ALUctrl),
        .ImmOp    (ImmOp),
        .WE3      (WE3),
        .AD1      (AD1),
        .AD2      (AD2),
        .AD3      (AD3),
        .pc       (pc),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] e_pc;
        logic [31:0] e_ret;
        logic [31:0] e_imm;
        logic        e_ill;
        int unsigned e_we3;
        int unsigned e_cyc;
        logic [4:0]  e_ad1, e_ad2, e_ad3;
        logic        e_src, e_ctrl;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic expect_instr(input logic [31:0] pc_after, input logic [31:0] ret,
                                input logic [31:0] imm, input logic ill,
                                input int unsigned we3, input int unsigned cyc,
                                input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                                input logic src, input logic ctrl);
        exp_t e;
        e.e_pc = pc_after; e.e_ret = ret; e.e_imm = imm; e.e_ill = ill;
        e.e_we3 = we3; e.e_cyc = cyc;
        e.e_ad1 = a1; e.e_ad2 = a2; e.e_ad3 = a3;
        e.e_src = src; e.e_ctrl = ctrl;
        sbq.push_back(e);
    endtask

    // Wait for a request, optionally stall d cycles, then ack for one cycle.
    // Returns on the negedge inside DECODE.
    task automatic issue(input logic [31:0] instr, input int unsigned d,
                         input logic eq, input logic [31:0] cur_pc);
        int unsigned n = 0;
        @(negedge clk);
        while (imem_req !== 1'b1) begin
            n++;
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_timeout: imem_req stayed 0 for %0d cycles, expected 1", n);
                finish_run();
            end
            @(negedge clk);
        end
        chk("fetch_addr", imem_addr, cur_pc);
        for (int unsigned i = 0; i < d; i++) begin
            imem_data = ~instr;
            @(negedge clk);
            chk("stall_req", imem_req, 1'b1);
            chk("stall_addr", imem_addr, cur_pc);
        end
        imem_ack  = 1'b1;
        imem_data = instr;
        EQ        = eq;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = ~instr;
    endtask

    // Monitor: tracks the EXEC cycle, counts WE3 cycles, compares on retire
    int unsigned idx = 0;
    initial begin
        logic        prev_req = 1'b0;
        logic [31:0] prev_ret = '0;
        int unsigned phase = 0, cyc = 0, we3cnt = 0;
        logic [4:0]  c_ad1 = '0, c_ad2 = '0, c_ad3 = '0;
        logic [31:0] c_imm = '0;
        logic        c_src = 1'b0, c_ctrl = 1'b0;
        exp_t        e;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                prev_req = 1'b0;
                prev_ret = '0;
                phase = 0; cyc = 0; we3cnt = 0;
            end else begin
                cyc++;
                if (WE3) we3cnt++;
                if (phase == 1) begin
                    c_ad1 = AD1; c_ad2 = AD2; c_ad3 = AD3;
                    c_imm = ImmOp; c_src = ALUsrc; c_ctrl = ALUctrl;
                    phase = 2;
                end
                if (prev_req && !imem_req) phase = 1;
                if (retired !== prev_ret) begin
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_retire: retired=%0d with empty scoreboard", retired);
                    end else begin
                        e = sbq.pop_front();
                        chk($sformatf("i%0d_pc", idx), pc, e.e_pc);
                        chk($sformatf("i%0d_retired", idx), retired, e.e_ret);
                        chk($sformatf("i%0d_illegal", idx), illegal, e.e_ill);
                        chk($sformatf("i%0d_we3_cycles", idx), we3cnt, e.e_we3);
                        chk($sformatf("i%0d_phase", idx), phase, 2);
                        chk($sformatf("i%0d_AD1", idx), c_ad1, e.e_ad1);
                        chk($sformatf("i%0d_AD2", idx), c_ad2, e.e_ad2);
                        chk($sformatf("i%0d_AD3", idx), c_ad3, e.e_ad3);
                        chk($sformatf("i%0d_ImmOp", idx), c_imm, e.e_imm);
                        chk($sformatf("i%0d_ALUsrc", idx), c_src, e.e_src);
                        chk($sformatf("i%0d_ALUctrl", idx), c_ctrl, e.e_ctrl);
                        if (e.e_cyc != 0) chk($sformatf("i%0d_cycles", idx), cyc, e.e_cyc);
                    end
                    idx++;
                    phase = 0; cyc = 0; we3cnt = 0;
                end
                prev_req = imem_req;
                prev_ret = retired;
            end
        end
    end

    // Directed program
    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_data = '0; EQ = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_we3", WE3, 1'b0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_illegal", illegal, 1'b0);
        rst = 1'b0;

        // addi x10,x0,5
        expect_instr(32'h4, 32'd1, 32'h5, 1'b0, 1, 0, 5'd0, 5'd5, 5'd10, 1'b1, 1'b0);
        issue(32'h00500513, 0, 1'b0, 32'h0);
        // bne x10,x11,+28 taken
        expect_instr(32'h20, 32'd2, 32'h1C, 1'b0, 0, 3, 5'd10, 5'd11, 5'd28, 1'b0, 1'b1);
        issue(32'h00B51E63, 0, 1'b0, 32'h4);
        // bne x10,x11,-8 taken (EQ=0)
        expect_instr(32'h18, 32'd3, 32'hFFFFFFF8, 1'b0, 0, 3, 5'd10, 5'd11, 5'd25, 1'b0, 1'b1);
        issue(32'hFEB51CE3, 0, 1'b0, 32'h20);
        // addi x5,x6,-1 with a 3-cycle ack stall
        expect_instr(32'h1C, 32'd4, 32'hFFFFFFFF, 1'b0, 1, 6, 5'd6, 5'd31, 5'd5, 1'b1, 1'b0);
        issue(32'hFFF30293, 3, 1'b0, 32'h18);
        // illegal all-zero word, 1-cycle stall
        expect_instr(32'h20, 32'd5, 32'h0, 1'b1, 0, 4, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(32'h00000000, 1, 1'b0, 32'h1C);
        // bne x10,x11,-8 not taken (EQ=1)
        expect_instr(32'h24, 32'd6, 32'hFFFFFFF8, 1'b1, 0, 3, 5'd10, 5'd11, 5'd25, 1'b0, 1'b1);
        issue(32'hFEB51CE3, 0, 1'b1, 32'h20);
        // addi still executes after illegal
        expect_instr(32'h28, 32'd7, 32'h5, 1'b1, 1, 3, 5'd0, 5'd5, 5'd10, 1'b1, 1'b0);
        issue(32'h00500513, 0, 1'b0, 32'h24);

        // reset during EXEC of an addi: nothing retires
        issue(32'h00500513, 0, 1'b0, 32'h28);
        @(negedge clk);
        chk("exec_we3", WE3, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we3", WE3, 1'b0);
        chk("abort_pc", pc, 32'h0);
        chk("abort_retired", retired, 32'h0);
        chk("abort_illegal", illegal, 1'b0);
        chk("abort_req", imem_req, 1'b0);
        rst = 1'b0;

        // bne x0,x0,-4 from 0 wraps to 0xFFFFFFFC, then addi wraps to 0
        expect_instr(32'hFFFFFFFC, 32'd1, 32'hFFFFFFFC, 1'b0, 0, 0, 5'd0, 5'd0, 5'd29, 1'b0, 1'b1);
        issue(32'hFE001EE3, 0, 1'b0, 32'h0);
        expect_instr(32'h0, 32'd2, 32'h5, 1'b0, 1, 3, 5'd0, 5'd5, 5'd10, 1'b1, 1'b0);
        issue(32'h00500513, 0, 1'b0, 32'hFFFFFFFC);

        repeat (6) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        chk("retire_count", idx, 9);
        finish_run();
    end

    initial begin
        #100000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        finish_run();
    end

endmodule
